// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite responder in front of a flop-based word memory with byte-lane writes,
// a fixed number of wait states per beat and the two-cycle ERROR response.
module ahb3lite_sram_slave #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int          IDX_W   = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;
    logic              hreadyout_q, hreadyout_d;
    logic              hresp_q, hresp_d;
    logic [31:0]       mem_q [DEPTH];

    logic              sample;
    logic              addr_err;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        lane_mask;

    always_comb begin
        addr_err = 1'b0;
        if (HSIZE > 3'b010)                           addr_err = 1'b1;
        if (HSIZE == 3'b001 && HADDR[0])              addr_err = 1'b1;
        if (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)   addr_err = 1'b1;
        if (32'(HADDR[ADDR_W-1:2]) >= DEPTH_L)        addr_err = 1'b1;
    end

    // Only states that drive HREADYOUT high can accept a new address phase.
    assign sample = HSEL && HREADY && HTRANS[1] &&
                    (state_q inside {ST_IDLE, ST_ACCESS, ST_ERR2});

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        size_d     = size_q;
        case (state_q)
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) state_d = ST_ACCESS;
                else                    wait_cnt_d = wait_cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (sample) begin
                    addr_d  = HADDR[ADDR_W-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = 4'(WAIT_STATES - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        hreadyout_d = !(state_d inside {ST_WAIT, ST_ERR1});
        hresp_d     = state_d inside {ST_ERR1, ST_ERR2};
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign idx = addr_q[IDX_W+1:2];

    always_comb begin
        case (size_q[1:0])
            2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
            2'b01:   lane_mask = 4'b0011 << addr_q[1:0];
            default: lane_mask = 4'b1111;
        endcase
    end

    // Memory is deliberately not reset; reset forces IDLE so a pending write is dropped.
    always_ff @(posedge HCLK) begin
        if (state_q == ST_ACCESS && write_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_mask[i]) mem_q[idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        if (state_q == ST_ACCESS && !write_q) HRDATA = mem_q[idx];
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HTRANS[0], HADDR[31:ADDR_W],
                         addr_q[ADDR_W-1:IDX_W+2], size_q[2]};

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench for ahb3lite_sram_slave: three instances with 0, 2 and 3 wait
// states share one bus; each instance's HREADY is its own HREADYOUT.
module tb_ahb3lite_sram_slave;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;
    localparam logic [1:0] TR_IDLE = 2'b00;
    localparam logic [1:0] TR_BUSY = 2'b01;
    localparam logic [1:0] TR_NSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       hsel;
    logic [31:0]      haddr, hwdata;
    logic [1:0]       htrans;
    logic             hwrite;
    logic [2:0]       hsize, hburst;
    logic [2:0]       ready, resp;
    logic [2:0][31:0] rdata;

    int errors = 0;
    int checks = 0;
    int ws_of [3] = '{0, 2, 3};

    always #5 clk = ~clk;

    ahb3lite_sram_slave #(.DEPTH(256), .ADDR_W(16), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(ready[0]), .HREADYOUT(ready[0]), .HRESP(resp[0]), .HRDATA(rdata[0]));

    ahb3lite_sram_slave #(.DEPTH(256), .ADDR_W(16), .WAIT_STATES(2)) u_ws2 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(ready[1]), .HREADYOUT(ready[1]), .HRESP(resp[1]), .HRDATA(rdata[1]));

    ahb3lite_sram_slave #(.DEPTH(256), .ADDR_W(16), .WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(ready[2]), .HREADYOUT(ready[2]), .HRESP(resp[2]), .HRDATA(rdata[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One single transfer to instance d; reports data-phase length and HRESP.
    task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic [31:0] wd,
                        output logic [31:0] rd, output int waits,
                        output logic resp_wait, output logic resp_end);
        hsel      = '0;
        hsel[d]   = 1'b1;
        haddr     = addr;
        htrans    = TR_NSEQ;
        hwrite    = wr;
        hsize     = size;
        hburst    = 3'b000;
        step();
        hsel      = '0;
        htrans    = TR_IDLE;
        hwdata    = wd;
        waits     = 0;
        resp_wait = 1'b0;
        while (ready[d] !== 1'b1 && waits < 20) begin
            resp_wait = resp_wait | resp[d];
            waits++;
            step();
        end
        rd       = rdata[d];
        resp_end = resp[d];
        step();
    endtask

    task automatic do_write(input int d, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wd, input string tag);
        logic [31:0] rd;
        int          waits;
        logic        rw, re;
        xfer(d, addr, 1'b1, size, wd, rd, waits, rw, re);
        chk({tag, "_resp"}, 32'(re), 32'd0);
    endtask

    task automatic do_read(input int d, input logic [31:0] addr, input logic [31:0] exp,
                           input string tag);
        logic [31:0] rd;
        int          waits;
        logic        rw, re;
        xfer(d, addr, 1'b0, SZ_WORD, 32'h0, rd, waits, rw, re);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_waits"}, 32'(waits), 32'(ws_of[d]));
    endtask

    task automatic err_check(input int d, input logic [31:0] addr, input logic wr,
                             input logic [2:0] size, input string tag);
        logic [31:0] rd;
        int          waits;
        logic        rw, re;
        xfer(d, addr, wr, size, 32'hFFFF_FFFF, rd, waits, rw, re);
        chk({tag, "_ready_low_cycles"}, 32'(waits), 32'd1);
        chk({tag, "_resp_err1"}, 32'(rw), 32'd1);
        chk({tag, "_resp_err2"}, 32'(re), 32'd1);
        chk({tag, "_rdata_err2"}, rd, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;
        rst    = 1'b1;
        hsel   = '0;
        haddr  = '0;
        htrans = TR_IDLE;
        hwrite = 1'b0;
        hsize  = SZ_WORD;
        hburst = 3'b000;
        hwdata = '0;
        #1;
        chk("reset_ready", 32'(ready), 32'h7);
        chk("reset_resp", 32'(resp), 32'h0);
        chk("reset_rdata", rdata[0], 32'h0);
        step();
        rst = 1'b0;
        step();

        // Byte and half lanes
        do_write(0, 32'h10, SZ_WORD, 32'h1122_3344, "lane_word_wr");
        do_write(0, 32'h13, SZ_BYTE, 32'hAA00_0000, "lane_byte_wr");
        do_read (0, 32'h10, 32'hAA22_3344, "lane_byte_rd");
        do_write(0, 32'h12, SZ_HALF, 32'hBBBB_0000, "lane_half_wr");
        do_read (0, 32'h10, 32'hBBBB_3344, "lane_half_rd");

        // INCR4 write then INCR4 read at zero wait states
        hburst = 3'b011;
        hsize  = SZ_WORD;
        hwrite = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                hsel   = 3'b001;
                haddr  = 32'h40 + 32'(4 * i);
                htrans = (i == 0) ? TR_NSEQ : TR_SEQ;
            end else begin
                hsel   = '0;
                htrans = TR_IDLE;
            end
            if (i > 0) begin
                hwdata = 32'(i - 1);
                chk("incr4_wr_ready", 32'(ready[0]), 32'd1);
            end
            step();
        end
        hwrite = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                hsel   = 3'b001;
                haddr  = 32'h40 + 32'(4 * i);
                htrans = (i == 0) ? TR_NSEQ : TR_SEQ;
            end else begin
                hsel   = '0;
                htrans = TR_IDLE;
            end
            if (i > 0) begin
                chk("incr4_rd_ready", 32'(ready[0]), 32'd1);
                chk("incr4_rd_data", rdata[0], 32'(i - 1));
            end
            step();
        end
        hburst = 3'b000;

        // Write immediately followed by read of the same word
        hsel   = 3'b001;
        haddr  = 32'h20;
        htrans = TR_NSEQ;
        hwrite = 1'b1;
        hsize  = SZ_WORD;
        step();
        hwrite = 1'b0;
        hwdata = 32'hDEAD_BEEF;
        chk("wr_rd_wr_ready", 32'(ready[0]), 32'd1);
        step();
        hsel   = '0;
        htrans = TR_IDLE;
        chk("wr_rd_rd_ready", 32'(ready[0]), 32'd1);
        chk("wr_rd_rd_data", rdata[0], 32'hDEAD_BEEF);
        step();

        // Error responses
        do_write(0, 32'h00, SZ_WORD, 32'h0102_0304, "err_pre_wr");
        err_check(0, 32'h02, 1'b1, SZ_WORD, "err_misaligned");
        do_read (0, 32'h00, 32'h0102_0304, "err_mem_kept");
        err_check(0, 32'h400, 1'b0, SZ_WORD, "err_out_of_range");
        err_check(0, 32'h08, 1'b0, 3'b011, "err_bad_size");

        // Wait states, with a BUSY between SEQ beats
        do_write(2, 32'h04, SZ_WORD, 32'h0000_0055, "ws3_wr_a");
        do_write(2, 32'h08, SZ_WORD, 32'h0000_0066, "ws3_wr_b");
        do_read (2, 32'h04, 32'h0000_0055, "ws3_single_rd");
        hsel   = 3'b100;
        haddr  = 32'h04;
        htrans = TR_NSEQ;
        hwrite = 1'b0;
        hsize  = SZ_WORD;
        step();
        haddr  = 32'h08;
        htrans = TR_BUSY;
        n = 0;
        while (ready[2] !== 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk("busy_beat0_waits", 32'(n), 32'd3);
        chk("busy_beat0_data", rdata[2], 32'h0000_0055);
        step();
        chk("busy_okay_ready", 32'(ready[2]), 32'd1);
        chk("busy_okay_resp", 32'(resp[2]), 32'd0);
        chk("busy_okay_rdata", rdata[2], 32'h0);
        htrans = TR_SEQ;
        step();
        hsel   = '0;
        htrans = TR_IDLE;
        n = 0;
        while (ready[2] !== 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk("busy_beat1_waits", 32'(n), 32'd3);
        chk("busy_beat1_data", rdata[2], 32'h0000_0066);
        step();

        // Reset during the wait phase of a write
        do_write(1, 32'h30, SZ_WORD, 32'h1234_5678, "rst_mid_pre_wr");
        hsel   = 3'b010;
        haddr  = 32'h30;
        htrans = TR_NSEQ;
        hwrite = 1'b1;
        hsize  = SZ_WORD;
        step();
        hsel   = '0;
        htrans = TR_IDLE;
        hwdata = 32'hCAFE_F00D;
        chk("rst_mid_in_wait", 32'(ready[1]), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(ready[1]), 32'd1);
        chk("rst_mid_resp", 32'(resp[1]), 32'd0);
        chk("rst_mid_rdata", rdata[1], 32'h0);
        step();
        rst = 1'b0;
        do_read(1, 32'h30, 32'h1234_5678, "rst_mid_mem");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb3lite_sram_slave.md
# ahb3lite_sram_slave

- AHB-Lite responder fronting a flop-based word memory.
- Completes the transfers generated by `ahb3lite_master_adapter`: SINGLE, INCR and INCR4/8/16 NONSEQ/SEQ sequences, sustaining 1 beat/clk at zero wait states.
- Byte/half/word writes go through per-lane masks; a programmable number of wait states is inserted per beat.
- Out-of-range and misaligned accesses get the two-cycle ERROR response.
- Sits behind the interconnect address decoder, which drives HSEL.

## Interface

Parameters:
- DEPTH, 256: memory size in 32-bit words (power of two, ≥4).
- ADDR_W, 16: decoded offset width; HADDR[31:ADDR_W] ignored.
- WAIT_STATES, 0: HREADYOUT-low cycles per beat (0..15).

Ports:
- HCLK  in  1  clock; all state changes on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  transfer address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write.
- HSIZE  in  3  000 byte, 001 half, 010 word; others illegal.
- HBURST  in  3  accepted; has no effect on behaviour.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready (muxed HREADYOUT of the active slave).
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data, full word; the master selects lanes.

## Operation

**Address-phase sample.** On a rising edge with HSEL & HREADY & HTRANS[1]=1, capture the following into the data-phase registers:
- HADDR[ADDR_W-1:0]
- HWRITE
- HSIZE
- error flag

If HSEL=0, HTRANS=IDLE or HTRANS=BUSY, nothing is captured. Those cycles get a zero-wait OKAY (HREADYOUT=1, HRESP=0), and memory is never touched.

**Error flag.** Set if any of the following holds:
- HSIZE > 010.
- HSIZE=001 and HADDR[0]=1.
- HSIZE=010 and HADDR[1:0]≠00.
- Word index HADDR[ADDR_W-1:2] ≥ DEPTH.

**Lane mask** from the captured size and addr[1:0]:
- byte → 0001 << addr[1:0]
- half → 0011 << addr[1:0]
- word → 1111

**States:**
- IDLE: no pending data phase. HREADYOUT=1, HRESP=0, HRDATA=0.
- WAIT: wait counter > 0. HREADYOUT=0, HRESP=0.
- ACCESS: final data cycle. HREADYOUT=1, HRESP=0.
  - Read: HRDATA = mem[idx] (combinational from the array).
  - Write: on the closing edge, mem[idx] lanes in the mask ← HWDATA lanes; other lanes are unchanged.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1. No memory write. HRDATA=0.

**Transitions**, evaluated on each edge:
- From IDLE, ACCESS or ERR2, a sample occurs:
  - error flag set → ERR1.
  - WAIT_STATES=0 → ACCESS.
  - otherwise → WAIT, with counter=WAIT_STATES-1.
- From IDLE, ACCESS or ERR2, no sample → IDLE.
- WAIT: counter=0 → ACCESS, else decrement.
- ERR1 → ERR2, unconditionally.
- No sampling occurs in WAIT or ERR1, because HREADY=0 there.

**Hazards.**
- A write in ACCESS commits on the same edge at which the next address is sampled.
- A following read of the same word therefore sees the new data with no stall or forwarding.
- A master that abandons a burst after ERR1 by driving IDLE during ERR2 is legal. Whatever is presented during ERR2 is sampled normally.

## Timing

**Reset.** HRESET high asynchronously forces:
- state=IDLE
- HREADYOUT=1
- HRESP=0
- HRDATA=0
- wait counter and captured registers = 0

Memory contents are not reset. A data phase in flight at reset is dropped, and its write is not committed.

**Latency.**
- Data phase lasts 1+WAIT_STATES cycles after the address phase.
- Back-to-back NONSEQ/SEQ at WAIT_STATES=0 runs 1 beat/clk with HREADYOUT held high.
- ERROR response is always exactly 2 cycles: HREADYOUT 0 then 1, HRESP high in both.

**Other rules.**
- HRESP and HREADYOUT are registered, from state, and glitch-free.
- HRDATA is valid only in the ACCESS cycle of a read.

## Test plan

- **Reset mid-transfer.** Assert HRESET during WAIT of a write (WAIT_STATES=2) → outputs return to reset values immediately; the target word is unchanged.
- **Byte lanes.** Word write 0x11223344 @0x10, then byte write HWDATA=0xAA000000 @0x13, then word read @0x10 → 0xAA223344. Repeat with a half write 0xBBBB0000 @0x12 → 0xBBBB3344.
- **INCR4 burst, WAIT_STATES=0.** Writes 0x0,0x1,0x2,0x3 at 0x40..0x4C, then INCR4 read → HREADYOUT never low, data returned on 4 consecutive cycles, 1 beat/clk.
- **Wait states.** WAIT_STATES=3, single read → exactly 3 cycles HREADYOUT=0, then HREADYOUT=1 with data. A BUSY inserted between SEQ beats gets an OKAY response with no memory access.
- **Errors.**
  - Word write @0x02 → ERR1/ERR2 (HRESP=1 both cycles, HREADYOUT 0 then 1), memory unchanged.
  - Word read @DEPTH*4 → the same two-cycle ERROR response.
  - HSIZE=011 → the same two-cycle ERROR response.
- **Write-then-read, same word.** Write 0xDEADBEEF @0x20 immediately followed by a read @0x20 → 0xDEADBEEF with zero stall.
